// File: rtl/spec_path_detector_pkg.sv
// Shared constants and types for the speculated-subpath detector.
package spec_path_detector_pkg;

    localparam int unsigned ADDR_W        = 16;
    localparam int unsigned NUM_PATHS_DEF = 2;
    localparam int unsigned MAX_LEN_DEF   = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dest;
    } cflow_pair_t;

endpackage

// File: rtl/spec_path_matcher.sv
// One speculated path: table, length, match progress and start address.
module spec_path_matcher
    import spec_path_detector_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
    input  logic                       clk,
    input  logic                       puc_n,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       clear_all,
    input  logic                       cflow_hw_wen,
    input  logic [ADDR_W-1:0]          cflow_log_ptr,
    input  logic [ADDR_W-1:0]          cflow_src,
    input  logic [ADDR_W-1:0]          cflow_dest,
    input  logic                       cfg_wen,
    input  logic [$clog2(MAX_LEN)-1:0] cfg_idx,
    input  logic                       cfg_len_wen,
    input  logic [$clog2(MAX_LEN):0]   cfg_len,
    input  logic [ADDR_W-1:0]          cfg_src,
    input  logic [ADDR_W-1:0]          cfg_dest,
    output logic                       complete,
    output logic [ADDR_W-1:0]          start_addr
);

    localparam int unsigned PW = $clog2(MAX_LEN);

    cflow_pair_t        entry_q [MAX_LEN];
    logic [PW:0]        len_q;
    logic [PW-1:0]      prog_q, prog_d;
    logic [ADDR_W-1:0]  start_q, start_d;

    cflow_pair_t pair;
    logic        valid, last, eval, match_cur, match_first, cfg_hit;

    assign pair        = '{src: cflow_src, dest: cflow_dest};
    assign valid       = (len_q != '0) && (len_q <= (PW+1)'(MAX_LEN));
    assign last        = ({1'b0, prog_q} == (len_q - (PW+1)'(1)));
    assign match_cur   = (pair == entry_q[prog_q]);
    assign match_first = (pair == entry_q[0]);
    assign cfg_hit     = cfg_wen | cfg_len_wen;
    // A table write to this path voids any in-flight match, including a completion.
    assign eval        = cflow_hw_wen & en & ~flush & valid & ~cfg_hit;

    always_comb begin
        complete   = 1'b0;
        prog_d     = prog_q;
        start_d    = start_q;
        start_addr = cflow_log_ptr;
        if (eval) begin
            if (match_cur) begin
                if (prog_q == '0) begin
                    start_d = cflow_log_ptr;
                end else begin
                    start_addr = start_q;
                end
                if (last) begin
                    complete = 1'b1;
                end else begin
                    prog_d = prog_q + PW'(1);
                end
            end else if (match_first) begin
                start_d = cflow_log_ptr;
                if (len_q == (PW+1)'(1)) begin
                    complete = 1'b1;
                end else begin
                    prog_d = PW'(1);
                end
            end else begin
                prog_d = '0;
            end
        end
        if (!en || flush || cfg_hit || clear_all) begin
            prog_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!puc_n) begin
            prog_q <= '0;
            len_q  <= '0;
        end else begin
            prog_q <= prog_d;
            if (cfg_len_wen) begin
                len_q <= cfg_len;
            end
        end
    end

    // Table and start address are deliberately left unreset.
    always_ff @(posedge clk) begin
        start_q <= start_d;
        if (cfg_wen) begin
            entry_q[cfg_idx] <= '{src: cfg_src, dest: cfg_dest};
        end
    end

endmodule

// File: rtl/spec_path_detector.sv
// Matches the CFLog write stream against speculated paths; pulses on a complete match.
module spec_path_detector
    import spec_path_detector_pkg::*;
#(
    parameter int unsigned NUM_PATHS = NUM_PATHS_DEF,
    parameter int unsigned MAX_LEN   = MAX_LEN_DEF,
    parameter int unsigned IDW       = (NUM_PATHS > 1) ? $clog2(NUM_PATHS) : 1
) (
    input  logic                       clk,
    input  logic                       puc_n,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       cflow_hw_wen,
    input  logic [ADDR_W-1:0]          cflow_log_ptr,
    input  logic [ADDR_W-1:0]          cflow_src,
    input  logic [ADDR_W-1:0]          cflow_dest,
    input  logic                       cfg_wen,
    input  logic [IDW-1:0]             cfg_path,
    input  logic [$clog2(MAX_LEN)-1:0] cfg_idx,
    input  logic                       cfg_len_wen,
    input  logic [$clog2(MAX_LEN):0]   cfg_len,
    input  logic [ADDR_W-1:0]          cfg_src,
    input  logic [ADDR_W-1:0]          cfg_dest,
    output logic                       detect_active,
    output logic [ADDR_W-1:0]          active_block_cflog_addr,
    output logic [IDW-1:0]             detect_id
);

    logic [NUM_PATHS-1:0] complete;
    logic [ADDR_W-1:0]    start_addr [NUM_PATHS];
    logic                 any_complete;
    logic [IDW-1:0]       sel_id;
    logic [ADDR_W-1:0]    sel_addr;

    logic                 det_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [IDW-1:0]       id_q;

    assign any_complete = |complete;

    for (genvar p = 0; p < NUM_PATHS; p++) begin : g_path
        logic sel;
        assign sel = (cfg_path == IDW'(p));

        spec_path_matcher #(
            .MAX_LEN (MAX_LEN)
        ) u_matcher (
            .clk           (clk),
            .puc_n         (puc_n),
            .en            (en),
            .flush         (flush),
            .clear_all     (any_complete),
            .cflow_hw_wen  (cflow_hw_wen),
            .cflow_log_ptr (cflow_log_ptr),
            .cflow_src     (cflow_src),
            .cflow_dest    (cflow_dest),
            .cfg_wen       (cfg_wen & sel),
            .cfg_idx       (cfg_idx),
            .cfg_len_wen   (cfg_len_wen & sel),
            .cfg_len       (cfg_len),
            .cfg_src       (cfg_src),
            .cfg_dest      (cfg_dest),
            .complete      (complete[p]),
            .start_addr    (start_addr[p])
        );
    end

    // Descending scan so the lowest completing index is the one left selected.
    always_comb begin
        sel_id   = '0;
        sel_addr = '0;
        for (int i = NUM_PATHS - 1; i >= 0; i--) begin
            if (complete[i]) begin
                sel_id   = IDW'(i);
                sel_addr = start_addr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!puc_n) begin
            det_q  <= 1'b0;
            addr_q <= '0;
            id_q   <= '0;
        end else begin
            det_q <= any_complete;
            if (any_complete) begin
                addr_q <= sel_addr;
                id_q   <= sel_id;
            end
        end
    end

    assign detect_active           = det_q;
    assign active_block_cflog_addr = addr_q;
    assign detect_id               = id_q;

endmodule

// File: tb/tb_spec_path_detector.sv
// Self-checking bench: directed vector table, hand sequences and randomized model comparison.
module tb_spec_path_detector;

    localparam int NP = 2;
    localparam int ML = 4;

    logic        clk = 1'b0;
    logic        puc_n, en, flush, cflow_hw_wen;
    logic [15:0] cflow_log_ptr, cflow_src, cflow_dest;
    logic        cfg_wen, cfg_len_wen;
    logic [0:0]  cfg_path;
    logic [1:0]  cfg_idx;
    logic [2:0]  cfg_len;
    logic [15:0] cfg_src, cfg_dest;
    logic        detect_active;
    logic [15:0] active_block_cflog_addr;
    logic [0:0]  detect_id;

    always #5 clk = ~clk;

    spec_path_detector dut (
        .clk                     (clk),
        .puc_n                   (puc_n),
        .en                      (en),
        .flush                   (flush),
        .cflow_hw_wen            (cflow_hw_wen),
        .cflow_log_ptr           (cflow_log_ptr),
        .cflow_src               (cflow_src),
        .cflow_dest              (cflow_dest),
        .cfg_wen                 (cfg_wen),
        .cfg_path                (cfg_path),
        .cfg_idx                 (cfg_idx),
        .cfg_len_wen             (cfg_len_wen),
        .cfg_len                 (cfg_len),
        .cfg_src                 (cfg_src),
        .cfg_dest                (cfg_dest),
        .detect_active           (detect_active),
        .active_block_cflog_addr (active_block_cflog_addr),
        .detect_id               (detect_id)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: table, lengths, progress and start per path.
    logic [15:0] m_src [NP][ML];
    logic [15:0] m_dst [NP][ML];
    int          m_len [NP];
    int          m_prog[NP];
    logic [15:0] m_start[NP];
    logic        exp_det;
    logic [15:0] exp_addr;
    logic [15:0] exp_id;

    typedef struct {
        logic        wen;
        logic        flush;
        logic [15:0] ptr;
        logic [15:0] src;
        logic [15:0] dest;
        logic        exp_det;
        logic [15:0] exp_addr;
        logic [15:0] exp_id;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int          win;
        logic [15:0] waddr;
        int          np[NP];
        logic [15:0] ns[NP];
        logic        hit, done, ok;
        if (!puc_n) begin
            exp_det  = 1'b0;
            exp_addr = 16'h0;
            exp_id   = 16'h0;
            for (int p = 0; p < NP; p++) begin
                m_prog[p] = 0;
                m_len[p]  = 0;
            end
        end else begin
            win   = -1;
            waddr = 16'h0;
            for (int p = 0; p < NP; p++) begin
                np[p] = m_prog[p];
                ns[p] = m_start[p];
                hit   = (cfg_wen || cfg_len_wen) && (int'(cfg_path) == p);
                ok    = (m_len[p] >= 1) && (m_len[p] <= ML);
                done  = 1'b0;
                if (!en || flush || hit) begin
                    np[p] = 0;
                end else if (cflow_hw_wen && ok) begin
                    if (cflow_src == m_src[p][m_prog[p]] && cflow_dest == m_dst[p][m_prog[p]]) begin
                        if (m_prog[p] == 0) ns[p] = cflow_log_ptr;
                        if (m_prog[p] == m_len[p] - 1) done = 1'b1;
                        else np[p] = m_prog[p] + 1;
                    end else if (cflow_src == m_src[p][0] && cflow_dest == m_dst[p][0]) begin
                        ns[p] = cflow_log_ptr;
                        if (m_len[p] == 1) done = 1'b1;
                        else np[p] = 1;
                    end else begin
                        np[p] = 0;
                    end
                end
                if (done && win < 0) begin
                    win   = p;
                    waddr = ns[p];
                end
            end
            exp_det = (win >= 0);
            if (win >= 0) begin
                exp_addr = waddr;
                exp_id   = 16'(win);
                for (int p = 0; p < NP; p++) np[p] = 0;
            end
            for (int p = 0; p < NP; p++) begin
                m_prog[p]  = np[p];
                m_start[p] = ns[p];
            end
            if (cfg_len_wen) m_len[cfg_path] = int'(cfg_len);
        end
        if (cfg_wen) begin
            m_src[cfg_path][cfg_idx] = cfg_src;
            m_dst[cfg_path][cfg_idx] = cfg_dest;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("model_det", 16'(detect_active), 16'(exp_det));
        check("model_addr", active_block_cflog_addr, exp_addr);
        check("model_id", 16'(detect_id), exp_id);
    endtask

    task automatic cfg_entry(input int p, input int i, input logic [15:0] s, input logic [15:0] d);
        cfg_wen  = 1'b1;
        cfg_path = 1'(p);
        cfg_idx  = 2'(i);
        cfg_src  = s;
        cfg_dest = d;
        step();
        cfg_wen = 1'b0;
    endtask

    task automatic cfg_length(input int p, input int l);
        cfg_len_wen = 1'b1;
        cfg_path    = 1'(p);
        cfg_len     = 3'(l);
        step();
        cfg_len_wen = 1'b0;
    endtask

    task automatic send(input logic [15:0] ptr, input logic [15:0] s, input logic [15:0] d);
        cflow_hw_wen  = 1'b1;
        cflow_log_ptr = ptr;
        cflow_src     = s;
        cflow_dest    = d;
        step();
        cflow_hw_wen = 1'b0;
    endtask

    initial begin
        logic [15:0] ptr;
        puc_n = 1'b0; en = 1'b1; flush = 1'b0; cflow_hw_wen = 1'b0;
        cflow_log_ptr = '0; cflow_src = '0; cflow_dest = '0;
        cfg_wen = 1'b0; cfg_len_wen = 1'b0; cfg_path = '0; cfg_idx = '0; cfg_len = '0;
        cfg_src = '0; cfg_dest = '0;
        for (int p = 0; p < NP; p++) begin
            m_prog[p] = 0; m_len[p] = 0; m_start[p] = '0;
            for (int i = 0; i < ML; i++) begin
                m_src[p][i] = '0; m_dst[p][i] = '0;
            end
        end
        step();
        step();
        check("rst_det", 16'(detect_active), 16'h0);
        check("rst_addr", active_block_cflog_addr, 16'h0);
        check("rst_id", 16'(detect_id), 16'h0);
        puc_n = 1'b1;

        // Two-pair path: basic match, restart on repeated first pair, flush.
        vecs[0]  = '{1'b1, 1'b0, 16'h0400, 16'hE010, 16'hE100, 1'b0, 16'h0000, 16'h0};
        vecs[1]  = '{1'b1, 1'b0, 16'h0402, 16'hE120, 16'hE010, 1'b1, 16'h0400, 16'h0};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0400, 16'h0};
        vecs[3]  = '{1'b1, 1'b0, 16'h0400, 16'hE010, 16'hE100, 1'b0, 16'h0400, 16'h0};
        vecs[4]  = '{1'b1, 1'b0, 16'h0402, 16'hE010, 16'hE100, 1'b0, 16'h0400, 16'h0};
        vecs[5]  = '{1'b1, 1'b0, 16'h0404, 16'hE120, 16'hE010, 1'b1, 16'h0402, 16'h0};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0402, 16'h0};
        vecs[7]  = '{1'b1, 1'b0, 16'h0410, 16'hE010, 16'hE100, 1'b0, 16'h0402, 16'h0};
        vecs[8]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0402, 16'h0};
        vecs[9]  = '{1'b1, 1'b0, 16'h0412, 16'hE120, 16'hE010, 1'b0, 16'h0402, 16'h0};
        vecs[10] = '{1'b1, 1'b0, 16'h0414, 16'hE010, 16'hE100, 1'b0, 16'h0402, 16'h0};
        vecs[11] = '{1'b1, 1'b0, 16'h0416, 16'hE120, 16'hE010, 1'b1, 16'h0414, 16'h0};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0414, 16'h0};

        cfg_entry(0, 0, 16'hE010, 16'hE100);
        cfg_entry(0, 1, 16'hE120, 16'hE010);
        cfg_length(0, 2);
        for (int v = 0; v < 13; v++) begin
            cflow_hw_wen  = vecs[v].wen;
            flush         = vecs[v].flush;
            cflow_log_ptr = vecs[v].ptr;
            cflow_src     = vecs[v].src;
            cflow_dest    = vecs[v].dest;
            step();
            check($sformatf("vec%0d_det", v), 16'(detect_active), 16'(vecs[v].exp_det));
            check($sformatf("vec%0d_addr", v), active_block_cflog_addr, vecs[v].exp_addr);
            check($sformatf("vec%0d_id", v), 16'(detect_id), vecs[v].exp_id);
        end
        cflow_hw_wen = 1'b0;
        flush        = 1'b0;

        // Both paths length 1 on the same pair: lowest index wins, single pulse.
        cfg_entry(0, 0, 16'hE200, 16'hE201);
        cfg_length(0, 1);
        cfg_entry(1, 0, 16'hE200, 16'hE201);
        cfg_length(1, 1);
        send(16'h0500, 16'hE200, 16'hE201);
        check("len1_det", 16'(detect_active), 16'h1);
        check("len1_id", 16'(detect_id), 16'h0);
        check("len1_addr", active_block_cflog_addr, 16'h0500);
        step();
        check("len1_single", 16'(detect_active), 16'h0);

        // Config write to path 1 during its final pair; path 0 keeps its own progress.
        cfg_entry(0, 0, 16'hE310, 16'hE311);
        cfg_entry(0, 1, 16'hE320, 16'hE321);
        cfg_length(0, 2);
        cfg_entry(1, 0, 16'hE300, 16'hE301);
        cfg_entry(1, 1, 16'hE310, 16'hE311);
        cfg_entry(1, 2, 16'hE320, 16'hE321);
        cfg_length(1, 3);
        send(16'h0600, 16'hE300, 16'hE301);
        send(16'h0602, 16'hE310, 16'hE311);
        cfg_wen = 1'b1; cfg_path = 1'b1; cfg_idx = 2'd0; cfg_src = 16'hE300; cfg_dest = 16'hE301;
        send(16'h0604, 16'hE320, 16'hE321);
        cfg_wen = 1'b0;
        check("cfgw_p0_det", 16'(detect_active), 16'h1);
        check("cfgw_p0_id", 16'(detect_id), 16'h0);
        check("cfgw_p0_addr", active_block_cflog_addr, 16'h0602);
        cfg_length(0, 0);
        send(16'h0620, 16'hE300, 16'hE301);
        send(16'h0622, 16'hE310, 16'hE311);
        cfg_wen = 1'b1; cfg_path = 1'b1; cfg_idx = 2'd0; cfg_src = 16'hE300; cfg_dest = 16'hE301;
        send(16'h0624, 16'hE320, 16'hE321);
        cfg_wen = 1'b0;
        check("cfgw_p1_nodet", 16'(detect_active), 16'h0);
        send(16'h0630, 16'hE300, 16'hE301);
        send(16'h0632, 16'hE310, 16'hE311);
        send(16'h0634, 16'hE320, 16'hE321);
        check("p1_det", 16'(detect_active), 16'h1);
        check("p1_id", 16'(detect_id), 16'h1);
        check("p1_addr", active_block_cflog_addr, 16'h0630);

        // Reset coinciding with the final pair drops the completion.
        send(16'h0700, 16'hE300, 16'hE301);
        send(16'h0702, 16'hE310, 16'hE311);
        puc_n = 1'b0;
        send(16'h0704, 16'hE320, 16'hE321);
        puc_n = 1'b1;
        check("rstmid_det", 16'(detect_active), 16'h0);
        check("rstmid_addr", active_block_cflog_addr, 16'h0);
        check("rstmid_id", 16'(detect_id), 16'h0);

        // Randomized traffic from a small alphabet so matches are frequent.
        for (int p = 0; p < NP; p++) begin
            for (int i = 0; i < ML; i++) begin
                cfg_entry(p, i, 16'hA000 + 16'($urandom_range(0, 1)),
                          16'hB000 + 16'($urandom_range(0, 1)));
            end
            cfg_length(p, $urandom_range(1, 3));
        end
        ptr = 16'h1000;
        for (int c = 0; c < 3000; c++) begin
            puc_n         = ($urandom_range(0, 199) != 0);
            en            = ($urandom_range(0, 19) != 0);
            flush         = ($urandom_range(0, 29) == 0);
            cflow_hw_wen  = ($urandom_range(0, 3) != 0);
            cflow_log_ptr = ptr;
            cflow_src     = 16'hA000 + 16'($urandom_range(0, 1));
            cflow_dest    = 16'hB000 + 16'($urandom_range(0, 1));
            cfg_wen       = ($urandom_range(0, 49) == 0);
            cfg_len_wen   = ($urandom_range(0, 59) == 0);
            cfg_path      = 1'($urandom_range(0, 1));
            cfg_idx       = 2'($urandom_range(0, 3));
            cfg_len       = 3'($urandom_range(0, 6));
            cfg_src       = 16'hA000 + 16'($urandom_range(0, 1));
            cfg_dest      = 16'hB000 + 16'($urandom_range(0, 1));
            if (cflow_hw_wen) ptr = ptr + 16'd2;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
